// File: rtl/block_sync_130_if.sv
// Gearbox-to-aligner word interface plus the aligned block stream to the descrambler.
// master = gearbox/upstream side, slave = block aligner.
interface block_sync_130_if #(
  parameter int IN_W = 130
);
  logic [IN_W-1:0] par_in;
  logic            par_valid;
  logic            slip_req;
  logic [IN_W-3:0] blk_data;
  logic            blk_os;
  logic            blk_err;
  logic            blk_valid;
  logic            blk_lock;

  modport master (
    output par_in, par_valid,
    input  slip_req, blk_data, blk_os, blk_err, blk_valid, blk_lock
  );

  modport slave (
    input  par_in, par_valid,
    output slip_req, blk_data, blk_os, blk_err, blk_valid, blk_lock
  );
endinterface

// File: rtl/block_sync_130.sv
// 128b/130b block aligner: sync-header hunt/slip/lock FSM, header strip and block forwarding.
// Optional BLKSYNC_STATS_EN adds saturating header-error and lock-loss counters.
module block_sync_130 #(
  parameter int IN_W      = 130,
  parameter int HDR_W     = 2,
  parameter int LOCK_CNT  = 16,
  parameter int ERR_MAX   = 4,
  parameter int WIN       = 64,
  parameter int SLIP_WAIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  block_sync_130_if.slave bus
`ifdef BLKSYNC_STATS_EN
  ,
  output logic [15:0]     hdr_err_total,
  output logic [15:0]     lock_loss_total
`endif
);

  localparam int PAY_W  = IN_W - HDR_W;
  localparam int GOOD_W = (LOCK_CNT  > 1) ? $clog2(LOCK_CNT)  : 1;
  localparam int ERR_W  = (ERR_MAX   > 1) ? $clog2(ERR_MAX)   : 1;
  localparam int WIN_W  = (WIN       > 1) ? $clog2(WIN)       : 1;
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               slip_q, slip_d;
  logic [PAY_W-1:0]   data_q, data_d;
  logic               os_q, os_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic               lock_q, lock_d;

  logic [HDR_W-1:0]   hdr;
  logic               hdr_good;

  assign hdr      = bus.par_in[IN_W-1 -: HDR_W];
  assign hdr_good = (hdr == HDR_W'(1)) || (hdr == HDR_W'(2));

`ifdef BLKSYNC_STATS_EN
  logic hdr_err_inc;
  logic lock_loss_inc;
`endif

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    win_cnt_d  = win_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d     = 1'b0;
    data_d     = data_q;
    os_d       = 1'b0;
    err_d      = 1'b0;
    valid_d    = 1'b0;
    lock_d     = lock_q;
`ifdef BLKSYNC_STATS_EN
    hdr_err_inc   = 1'b0;
    lock_loss_inc = 1'b0;
`endif
    if (bus.par_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (hdr_good) begin
            if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
              state_d    = ST_LOCKED;
              lock_d     = 1'b1;
              good_cnt_d = '0;
              err_cnt_d  = '0;
              win_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else begin
            state_d    = ST_SLIP;
            slip_d     = 1'b1;
            good_cnt_d = '0;
            wait_cnt_d = '0;
          end
        end
        ST_SLIP: begin
          // The gearbox needs a few words to apply the slip; those words are not judged.
          if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
            state_d    = ST_HUNT;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          valid_d = 1'b1;
          data_d  = bus.par_in[PAY_W-1:0];
          os_d    = (hdr == HDR_W'(2));
          err_d   = !hdr_good;
`ifdef BLKSYNC_STATS_EN
          hdr_err_inc = !hdr_good;
`endif
          // Loss of lock outranks the window rollover on the same word.
          if (!hdr_good && (err_cnt_q == ERR_W'(ERR_MAX - 1))) begin
            state_d    = ST_HUNT;
            lock_d     = 1'b0;
            good_cnt_d = '0;
            err_cnt_d  = '0;
            win_cnt_d  = '0;
`ifdef BLKSYNC_STATS_EN
            lock_loss_inc = 1'b1;
`endif
          end else if (win_cnt_q == WIN_W'(WIN - 1)) begin
            win_cnt_d = '0;
            err_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (!hdr_good) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      win_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_q     <= 1'b0;
      data_q     <= '0;
      os_q       <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
      win_cnt_q  <= win_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q     <= slip_d;
      data_q     <= data_d;
      os_q       <= os_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
    end
  end

  assign bus.slip_req  = slip_q;
  assign bus.blk_data  = data_q;
  assign bus.blk_os    = os_q;
  assign bus.blk_err   = err_q;
  assign bus.blk_valid = valid_q;
  assign bus.blk_lock  = lock_q;

`ifdef BLKSYNC_STATS_EN
  logic [15:0] hdr_err_total_q;
  logic [15:0] lock_loss_total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_err_total_q   <= '0;
      lock_loss_total_q <= '0;
    end else begin
      if (hdr_err_inc && (hdr_err_total_q != 16'hFFFF)) begin
        hdr_err_total_q <= hdr_err_total_q + 16'd1;
      end
      if (lock_loss_inc && (lock_loss_total_q != 16'hFFFF)) begin
        lock_loss_total_q <= lock_loss_total_q + 16'd1;
      end
    end
  end

  assign hdr_err_total   = hdr_err_total_q;
  assign lock_loss_total = lock_loss_total_q;
`endif

endmodule

// File: tb/tb_block_sync_130.sv
// Directed bench for block_sync_130: word-level behavioural model checked every cycle,
// plus literal checks on lock timing, slip pulses, forwarding, window rules and reset.
module tb_block_sync_130;
  localparam int LOCK_CNT  = 16;
  localparam int ERR_MAX   = 4;
  localparam int WIN       = 64;
  localparam int SLIP_WAIT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_sync_130_if #(.IN_W(130)) bus ();

`ifdef BLKSYNC_STATS_EN
  logic [15:0] hdr_err_total;
  logic [15:0] lock_loss_total;
`endif

  block_sync_130 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BLKSYNC_STATS_EN
    ,
    .hdr_err_total   (hdr_err_total),
    .lock_loss_total (lock_loss_total)
`endif
  );

  int errors = 0;
  int checks = 0;
  int slips  = 0;
  bit chk_en = 1'b0;

  // Word-level model of the aligner.
  bit m_locked;
  int m_streak;
  int m_skip;
  int m_pos;
  int m_errs;
  int m_hdr_tot;
  int m_loss_tot;

  logic         nx_slip, nx_valid, nx_os, nx_err, nx_lock;
  logic [127:0] nx_data;
  logic         exp_slip, exp_valid, exp_os, exp_err, exp_lock;
  logic [127:0] exp_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_streak = 0; m_skip = 0; m_pos = 0; m_errs = 0;
    m_hdr_tot = 0; m_loss_tot = 0;
    nx_slip = 0; nx_valid = 0; nx_os = 0; nx_err = 0; nx_lock = 0; nx_data = '0;
    exp_slip = 0; exp_valid = 0; exp_os = 0; exp_err = 0; exp_lock = 0; exp_data = '0;
  endtask

  task automatic model_word(input logic [1:0] hdr, input logic [127:0] pl);
    bit good;
    good = (hdr == 2'b01) || (hdr == 2'b10);
    if (m_locked) begin
      nx_valid = 1'b1;
      nx_os    = (hdr == 2'b10);
      nx_err   = !good;
      nx_data  = pl;
      m_pos++;
      if (!good) begin
        m_errs++;
        if (m_hdr_tot < 65535) m_hdr_tot++;
      end
      if (m_errs == ERR_MAX) begin
        m_locked = 1'b0; nx_lock = 1'b0; m_streak = 0; m_pos = 0; m_errs = 0;
        if (m_loss_tot < 65535) m_loss_tot++;
      end else if (m_pos == WIN) begin
        m_pos = 0; m_errs = 0;
      end
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (good) begin
      m_streak++;
      if (m_streak == LOCK_CNT) begin
        m_locked = 1'b1; nx_lock = 1'b1; m_streak = 0; m_pos = 0; m_errs = 0;
      end
    end else begin
      m_streak = 0; m_skip = SLIP_WAIT; nx_slip = 1'b1;
    end
  endtask

  // One clock: present (or not) a word, advance the model, land just after the edge.
  task automatic tick(input logic v, input logic [1:0] hdr, input logic [127:0] pl);
    bus.par_valid = v;
    bus.par_in    = {hdr, pl};
    nx_slip = 0; nx_valid = 0; nx_os = 0; nx_err = 0;
    if (v) model_word(hdr, pl);
    @(posedge clk);
    #1;
    exp_slip = nx_slip; exp_valid = nx_valid; exp_os = nx_os;
    exp_err = nx_err; exp_lock = nx_lock; exp_data = nx_data;
    bus.par_valid = 1'b0;
    if (bus.slip_req) slips++;
  endtask

  task automatic word(input logic [1:0] h);
    logic [127:0] pl;
    pl = {$urandom, $urandom, $urandom, $urandom};
    tick(1'b1, h, pl);
  endtask

  task automatic idle();
    tick(1'b0, 2'b11, '1);
  endtask

  task automatic run_words(input int n, input int e0, input int e1, input int e2, input int e3);
    for (int i = 0; i < n; i++) begin
      if (i == e0 || i == e1 || i == e2 || i == e3) word((i % 2 == 1) ? 2'b00 : 2'b11);
      else word((i % 3 == 0) ? 2'b10 : 2'b01);
      if (i % 7 == 3) idle();
    end
  endtask

  task automatic relock();
    for (int i = 0; i < LOCK_CNT; i++) word(2'b01);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("slip_req", bus.slip_req, exp_slip);
      chk("blk_valid", bus.blk_valid, exp_valid);
      chk("blk_os", bus.blk_os, exp_os);
      chk("blk_err", bus.blk_err, exp_err);
      chk("blk_lock", bus.blk_lock, exp_lock);
      chk("blk_data", bus.blk_data, exp_data);
`ifdef BLKSYNC_STATS_EN
      chk("hdr_err_total", hdr_err_total, m_hdr_tot[15:0]);
      chk("lock_loss_total", lock_loss_total, m_loss_tot[15:0]);
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] pat;
    rst = 1'b1;
    bus.par_valid = 1'b0;
    bus.par_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_lock", bus.blk_lock, 1'b0);
    chk("reset_valid", bus.blk_valid, 1'b0);
    chk("reset_data", bus.blk_data, 128'h0);

    // Hunt: 5 good, bad header -> one slip, two ignored words, then 16 good to lock.
    slips = 0;
    repeat (5) word(2'b01);
    word(2'b11);
    chk("slip_pulse", bus.slip_req, 1'b1);
    word(2'b00);
    chk("slip_no_second", bus.slip_req, 1'b0);
    idle();
    word(2'b11);
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      word(2'b01);
      if (i == 6) idle();
    end
    chk("slip_count", slips, 1);
    chk("lock_before_16th", bus.blk_lock, 1'b0);
    word(2'b01);
    chk("lock_after_16th", bus.blk_lock, 1'b1);
    chk("no_fwd_16th", bus.blk_valid, 1'b0);

    // First forwarded word: ordered set with a known payload.
    pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tick(1'b1, 2'b10, pat);
    chk("os_valid", bus.blk_valid, 1'b1);
    chk("os_flag", bus.blk_os, 1'b1);
    chk("os_data", bus.blk_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    idle();
    chk("data_hold", bus.blk_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("idle_valid", bus.blk_valid, 1'b0);
    word(2'b01);
    chk("data_os0", bus.blk_os, 1'b0);

    // Windows: rest of window 1 with 3 errors, window 2 with 3 errors -> stays locked.
    run_words(WIN - 2, 3, 20, 41, -1);
    chk("win1_locked", bus.blk_lock, 1'b1);
    run_words(WIN, 0, 1, 63, -1);
    chk("win2_locked", bus.blk_lock, 1'b1);
    // Window 3: 4th error on the 64th word -> unlock takes priority over rollover.
    run_words(WIN - 1, 5, 30, 50, -1);
    chk("win3_pre_lock", bus.blk_lock, 1'b1);
    word(2'b11);
    chk("win3_last_err", bus.blk_err, 1'b1);
    chk("win3_last_valid", bus.blk_valid, 1'b1);
    chk("win3_unlock", bus.blk_lock, 1'b0);
    word(2'b01);
    chk("post_unlock_novalid", bus.blk_valid, 1'b0);

    // Relock, then 4 errors in a short burst.
    relock();
    chk("relock", bus.blk_lock, 1'b1);
    word(2'b11); word(2'b01); word(2'b00); word(2'b11);
    chk("burst_pre", bus.blk_lock, 1'b1);
    word(2'b11);
    chk("burst_unlock", bus.blk_lock, 1'b0);
    chk("burst_err", bus.blk_err, 1'b1);
    word(2'b10);
    chk("burst_stop", bus.blk_valid, 1'b0);

    // Reset mid-lock, with a bad word presented on the same edge.
    relock();
    word(2'b01);
    rst = 1'b1;
    bus.par_valid = 1'b1;
    bus.par_in = {2'b11, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF};
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    bus.par_valid = 1'b0;
    chk("rst_lock", bus.blk_lock, 1'b0);
    chk("rst_valid", bus.blk_valid, 1'b0);
    chk("rst_slip", bus.slip_req, 1'b0);
    chk("rst_data", bus.blk_data, 128'h0);

    // Two lock losses of 4 errors each.
    relock();
    word(2'b11); word(2'b11); word(2'b00); word(2'b11);
    relock();
    word(2'b00); word(2'b01); word(2'b11); word(2'b11); word(2'b00);
    chk("loss2_lock", bus.blk_lock, 1'b0);
`ifdef BLKSYNC_STATS_EN
    chk("stat_loss", lock_loss_total, 16'd2);
    chk("stat_hdr", hdr_err_total, 16'd8);
`endif
    idle();
    idle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
